// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: operating-mode encoding and the shared one-hot helper
// used by the scan_decoder block and its decoder sub-module.
package scan_decoder_pkg;

    // Largest select width the helper supports (64 outputs).
    localparam int unsigned MAX_SEL_W = 32'd6;
    localparam int unsigned MAX_N     = 32'd64;

    // Operating modes as seen on the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // One-hot encode a select index. sel_w is the select width of the
    // caller; bits at or above 2^sel_w are masked so a caller truncating
    // the result to its own output count never sees stray bits.
    function automatic logic [MAX_N-1:0] onehot(
        input logic [MAX_SEL_W-1:0] sel,
        input int unsigned          sel_w
    );
        logic [MAX_N-1:0] res_v;
        logic [MAX_N-1:0] mask_v;
        res_v  = {{(MAX_N-1){1'b0}}, 1'b1} << sel;
        mask_v = ~({MAX_N{1'b1}} << (32'd1 << sel_w));
        return res_v & mask_v;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: purely combinational SEL_W -> 2^SEL_W one-hot decoder with no
// enable. Gating and registering are done by the instantiating block.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 32'd2
) (
    input  logic [SEL_W-1:0]         sel,
    output logic [(1 << SEL_W)-1:0]  y
);

    localparam int unsigned N = 32'd1 << SEL_W;

    logic [MAX_SEL_W-1:0] sel_ext_s;

    assign sel_ext_s = MAX_SEL_W'(sel);
    assign y         = N'(onehot(sel_ext_s, SEL_W));

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with enable and three
// modes (direct decode, single-cycle strobe, self-timed scan with a
// programmable dwell). All outputs come straight from flops.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 32'd2,
    parameter int unsigned DWELL_W = 32'd8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     load,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [(1 << SEL_W)-1:0]  y,
    output logic [SEL_W-1:0]         idx,
    output logic                     wrap
);

    localparam int unsigned N = 32'd1 << SEL_W;

    // Registered state.
    logic [SEL_W-1:0]   idx_r;
    logic [DWELL_W-1:0] cnt_r;
    mode_e              prev_mode_r;

    // Next-state and decode signals.
    logic               mode_chg_s;
    logic [SEL_W-1:0]   idx_next_s;
    logic [DWELL_W-1:0] cnt_next_s;
    logic               wrap_next_s;
    logic [SEL_W-1:0]   dec_sel_s;
    logic [N-1:0]       dec_y_s;
    logic [N-1:0]       y_next_s;

    // Scan index / dwell counter next state and the index fed to the decoder.
    // In SCAN the decoder sees the index that will be registered this cycle,
    // so y and idx always agree (a preload shows up on y the next cycle).
    always_comb begin
        mode_chg_s  = (mode != prev_mode_r);
        idx_next_s  = idx_r;
        cnt_next_s  = cnt_r;
        wrap_next_s = 1'b0;
        dec_sel_s   = sel;
        case (mode_e'(mode))
            MODE_DIRECT, MODE_PULSE: begin
                if (mode_chg_s) begin
                    cnt_next_s = {DWELL_W{1'b0}};
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            MODE_SCAN: begin
                if (load) begin
                    // Preload wins over a due advance and never reports wrap.
                    idx_next_s = sel;
                    cnt_next_s = {DWELL_W{1'b0}};
                end else if (mode_chg_s) begin
                    // Entering SCAN starts a fresh, full dwell on the held idx.
                    cnt_next_s = {DWELL_W{1'b0}};
                end else if (cnt_r >= dwell) begin
                    // >= so that lowering dwell below the count advances at once.
                    idx_next_s  = idx_r + SEL_W'(1'b1);
                    cnt_next_s  = {DWELL_W{1'b0}};
                    wrap_next_s = &idx_r;
                end else begin
                    cnt_next_s = cnt_r + DWELL_W'(1'b1);
                end
                dec_sel_s = idx_next_s;
            end
            default: begin
                // Reserved mode: everything holds.
                cnt_next_s = cnt_r;
            end
        endcase
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel (dec_sel_s),
        .y   (dec_y_s)
    );

    // Output value for the next cycle according to the current mode.
    always_comb begin
        y_next_s = {N{1'b0}};
        case (mode_e'(mode))
            MODE_DIRECT: y_next_s = dec_y_s;
            MODE_PULSE: begin
                if (load) begin
                    y_next_s = dec_y_s;
                end else begin
                    y_next_s = {N{1'b0}};
                end
            end
            MODE_SCAN:   y_next_s = dec_y_s;
            default:     y_next_s = {N{1'b0}};
        endcase
    end

    // State and output registers; en low blanks outputs and freezes state.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= {SEL_W{1'b0}};
            cnt_r       <= {DWELL_W{1'b0}};
            prev_mode_r <= MODE_DIRECT;
            y           <= {N{1'b0}};
            wrap        <= 1'b0;
        end else if (en) begin
            idx_r       <= idx_next_s;
            cnt_r       <= cnt_next_s;
            prev_mode_r <= mode_e'(mode);
            y           <= y_next_s;
            wrap        <= wrap_next_s;
        end else begin
            y    <= {N{1'b0}};
            wrap <= 1'b0;
        end
    end

    assign idx = idx_r;

endmodule
